// File: rtl/first_nios2_system_sysid_checker_if.sv
// rtl/first_nios2_system_sysid_checker_if.sv - Avalon-MM read bus between the sysid checker and the system ID slave
interface first_nios2_system_sysid_checker_if;
    logic        m_address;
    logic        m_read;
    logic        m_waitrequest;
    logic [31:0] m_readdata;

    modport master (
        output m_address,
        output m_read,
        input  m_waitrequest,
        input  m_readdata
    );

    modport slave (
        input  m_address,
        input  m_read,
        output m_waitrequest,
        output m_readdata
    );
endinterface

// File: rtl/first_nios2_system_sysid_checker.sv
// rtl/first_nios2_system_sysid_checker.sv - boot-time sequencer that reads and verifies the system ID and build timestamp
module first_nios2_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1521056172,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          MAX_RETRIES        = 3,
    parameter int          AUTO_START         = 1
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                start,
    first_nios2_system_sysid_checker_if.master  bus,
    output logic                                busy,
    output logic                                done,
    output logic                                pass,
    output logic                                id_ok,
    output logic                                ts_ok,
    output logic                                timeout_err,
    output logic [3:0]                          retry_count,
    output logic [31:0]                         captured_id,
    output logic [31:0]                         captured_ts
);

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam logic [3:0]  RETRY_LIMIT   = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CHECK, DONE} state_t;

    state_t      state_q, state_d;
    logic        m_read_q, m_read_d;
    logic        m_address_q, m_address_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        busy_d, done_d, pass_d, id_ok_d, ts_ok_d, timeout_err_d;
    logic [3:0]  retry_count_d;
    logic [31:0] captured_id_d, captured_ts_d;
    logic        begin_check;
    logic        stalled, complete, timed_out;

    assign stalled   = m_read_q & bus.m_waitrequest;
    assign complete  = m_read_q & ~bus.m_waitrequest;
    assign timed_out = stalled && ((wait_cnt_q + 16'd1) == TIMEOUT_LIMIT);

    always_comb begin
        state_d       = state_q;
        m_read_d      = m_read_q;
        m_address_d   = m_address_q;
        wait_cnt_d    = wait_cnt_q;
        busy_d        = busy;
        done_d        = done;
        pass_d        = pass;
        id_ok_d       = id_ok;
        ts_ok_d       = ts_ok;
        timeout_err_d = timeout_err;
        retry_count_d = retry_count;
        captured_id_d = captured_id;
        captured_ts_d = captured_ts;
        begin_check   = 1'b0;

        case (state_q)
            IDLE: begin_check = (AUTO_START != 0) || start;
            DONE: begin_check = start;
            RD_ID, RD_TS: begin
                if (!m_read_q) begin
                    // Second half of an aborted read: strobe was low for one cycle, reissue from word 0.
                    m_read_d   = 1'b1;
                    wait_cnt_d = 16'd0;
                end else if (complete) begin
                    wait_cnt_d = 16'd0;
                    if (state_q == RD_ID) begin
                        captured_id_d = bus.m_readdata;
                        m_address_d   = 1'b1;
                        state_d       = RD_TS;
                    end else begin
                        captured_ts_d = bus.m_readdata;
                        m_read_d      = 1'b0;
                        state_d       = CHECK;
                    end
                end else if (timed_out) begin
                    m_read_d    = 1'b0;
                    m_address_d = 1'b0;
                    wait_cnt_d  = 16'd0;
                    if (retry_count < RETRY_LIMIT) begin
                        retry_count_d = retry_count + 4'd1;
                        state_d       = RD_ID;
                    end else begin
                        timeout_err_d = 1'b1;
                        pass_d        = 1'b0;
                        busy_d        = 1'b0;
                        done_d        = 1'b1;
                        state_d       = DONE;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            CHECK: begin
                id_ok_d = (captured_id == EXPECTED_ID);
                ts_ok_d = (captured_ts == EXPECTED_TIMESTAMP);
                pass_d  = (captured_id == EXPECTED_ID) && (captured_ts == EXPECTED_TIMESTAMP);
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        if (begin_check) begin
            state_d       = RD_ID;
            busy_d        = 1'b1;
            done_d        = 1'b0;
            pass_d        = 1'b0;
            id_ok_d       = 1'b0;
            ts_ok_d       = 1'b0;
            timeout_err_d = 1'b0;
            retry_count_d = 4'd0;
            m_read_d      = 1'b1;
            m_address_d   = 1'b0;
            wait_cnt_d    = 16'd0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            m_read_q    <= 1'b0;
            m_address_q <= 1'b0;
            wait_cnt_q  <= 16'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            retry_count <= 4'd0;
            captured_id <= 32'd0;
            captured_ts <= 32'd0;
        end else begin
            state_q     <= state_d;
            m_read_q    <= m_read_d;
            m_address_q <= m_address_d;
            wait_cnt_q  <= wait_cnt_d;
            busy        <= busy_d;
            done        <= done_d;
            pass        <= pass_d;
            id_ok       <= id_ok_d;
            ts_ok       <= ts_ok_d;
            timeout_err <= timeout_err_d;
            retry_count <= retry_count_d;
            captured_id <= captured_id_d;
            captured_ts <= captured_ts_d;
        end
    end

    assign bus.m_read    = m_read_q;
    assign bus.m_address = m_address_q;

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// tb/tb_first_nios2_system_sysid_checker.sv - directed self-checking bench for the sysid checker
module tb_first_nios2_system_sysid_checker;

    logic clock;
    logic reset_n;
    logic start;
    logic start_t;

    int n_checks;
    int n_fail;

    first_nios2_system_sysid_checker_if bus0 ();
    first_nios2_system_sysid_checker_if bus1 ();

    logic        busy, done, pass, id_ok, ts_ok, timeout_err;
    logic [3:0]  retry_count;
    logic [31:0] captured_id, captured_ts;

    logic        t_busy, t_done, t_pass, t_id_ok, t_ts_ok, t_timeout_err;
    logic [3:0]  t_retry_count;
    logic [31:0] t_captured_id, t_captured_ts;

    logic [31:0] id_val;
    logic [31:0] ts_val;
    int          stall_cfg;
    int          stall_cnt;

    first_nios2_system_sysid_checker u_dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .bus         (bus0),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .id_ok       (id_ok),
        .ts_ok       (ts_ok),
        .timeout_err (timeout_err),
        .retry_count (retry_count),
        .captured_id (captured_id),
        .captured_ts (captured_ts)
    );

    first_nios2_system_sysid_checker #(
        .TIMEOUT_CYCLES (8),
        .MAX_RETRIES    (2)
    ) u_dut_to (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start_t),
        .bus         (bus1),
        .busy        (t_busy),
        .done        (t_done),
        .pass        (t_pass),
        .id_ok       (t_id_ok),
        .ts_ok       (t_ts_ok),
        .timeout_err (t_timeout_err),
        .retry_count (t_retry_count),
        .captured_id (t_captured_id),
        .captured_ts (t_captured_ts)
    );

    // Slave model: zero-latency data, waitrequest high for stall_cfg cycles of each read.
    assign bus0.m_readdata    = bus0.m_address ? ts_val : id_val;
    assign bus0.m_waitrequest = bus0.m_read && (stall_cnt < stall_cfg);
    assign bus1.m_readdata    = 32'd0;
    assign bus1.m_waitrequest = 1'b1;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            stall_cnt <= 0;
        else if (bus0.m_read && bus0.m_waitrequest)
            stall_cnt <= stall_cnt + 1;
        else
            stall_cnt <= 0;
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        start_t = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (bus0.m_read !== 1'b0 || bus0.m_address !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_bus: got read=%b addr=%b, expected 0 0", bus0.m_read, bus0.m_address);
        end
        n_checks++;
        if ({busy, done, pass, id_ok, ts_ok, timeout_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, expected 000000", {busy, done, pass, id_ok, ts_ok, timeout_err});
        end
        n_checks++;
        if (retry_count !== 4'd0 || captured_id !== 32'd0 || captured_ts !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_regs: got retry=%0d id=%h ts=%h, expected 0 0 0", retry_count, captured_id, captured_ts);
        end
    endtask

    task automatic test_auto_pass();
        stall_cfg = 0;
        id_val    = 32'd0;
        ts_val    = 32'h5AA979AC;
        do_reset();
        tick();
        n_checks++;
        if (bus0.m_read !== 1'b1 || bus0.m_address !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_edge1: got read=%b addr=%b busy=%b done=%b, expected 1 0 1 0",
                     bus0.m_read, bus0.m_address, busy, done);
        end
        tick();
        n_checks++;
        if (bus0.m_read !== 1'b1 || bus0.m_address !== 1'b1) begin
            n_fail++;
            $display("FAIL pass_edge2: got read=%b addr=%b, expected 1 1", bus0.m_read, bus0.m_address);
        end
        tick();
        n_checks++;
        if (bus0.m_read !== 1'b0 || done !== 1'b0 || captured_ts !== 32'h5AA979AC) begin
            n_fail++;
            $display("FAIL pass_edge3: got read=%b done=%b ts=%h, expected 0 0 5aa979ac", bus0.m_read, done, captured_ts);
        end
        tick();
        n_checks++;
        if ({done, pass, busy, id_ok, ts_ok} !== 5'b11011) begin
            n_fail++;
            $display("FAIL pass_edge4: got done,pass,busy,id_ok,ts_ok=%b, expected 11011", {done, pass, busy, id_ok, ts_ok});
        end
        repeat (2) tick();
        n_checks++;
        if (bus0.m_read !== 1'b0 || done !== 1'b1 || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL pass_hold: got read=%b done=%b pass=%b, expected 0 1 1", bus0.m_read, done, pass);
        end
    endtask

    task automatic test_ts_mismatch();
        int rd;
        stall_cfg = 0;
        ts_val    = 32'h5AA979AD;
        do_reset();
        repeat (4) tick();
        n_checks++;
        if ({done, id_ok, ts_ok, pass, timeout_err} !== 5'b11000 || retry_count !== 4'd0) begin
            n_fail++;
            $display("FAIL mismatch_result: got done,id_ok,ts_ok,pass,to=%b retry=%0d, expected 11000 0",
                     {done, id_ok, ts_ok, pass, timeout_err}, retry_count);
        end
        rd = 0;
        repeat (8) begin
            tick();
            if (bus0.m_read) rd++;
        end
        n_checks++;
        if (rd != 0) begin
            n_fail++;
            $display("FAIL mismatch_no_retry: got %0d read cycles, expected 0", rd);
        end
        ts_val = 32'h5AA979AC;
    endtask

    task automatic test_waitrequest();
        stall_cfg = 3;
        do_reset();
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e <= 4) begin
                n_checks++;
                if (bus0.m_read !== 1'b1 || bus0.m_address !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wait_id_hold e%0d: got read=%b addr=%b, expected 1 0", e, bus0.m_read, bus0.m_address);
                end
            end else if (e <= 8) begin
                n_checks++;
                if (bus0.m_read !== 1'b1 || bus0.m_address !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wait_ts_hold e%0d: got read=%b addr=%b, expected 1 1", e, bus0.m_read, bus0.m_address);
                end
            end
            if (e == 9) begin
                n_checks++;
                if (done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wait_early_done: got done=%b at edge 9, expected 0", done);
                end
            end
        end
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b1 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_result: got done=%b pass=%b to=%b at edge 10, expected 1 1 0", done, pass, timeout_err);
        end
    endtask

    task automatic test_timeout();
        int   attempts;
        logic prev;
        attempts = 0;
        prev     = 1'b0;
        stall_cfg = 0;
        do_reset();
        for (int e = 1; e <= 27; e++) begin
            tick();
            if (bus1.m_read && !prev) attempts++;
            prev = bus1.m_read;
            if (e == 26) begin
                n_checks++;
                if (t_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_early_done: got done=%b at edge 26, expected 0", t_done);
                end
            end
        end
        n_checks++;
        if (t_done !== 1'b1 || t_timeout_err !== 1'b1 || t_pass !== 1'b0 || t_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_result: got done=%b to=%b pass=%b busy=%b, expected 1 1 0 0",
                     t_done, t_timeout_err, t_pass, t_busy);
        end
        n_checks++;
        if (t_retry_count !== 4'd2 || t_id_ok !== 1'b0 || t_ts_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_retries: got retry=%0d id_ok=%b ts_ok=%b, expected 2 0 0", t_retry_count, t_id_ok, t_ts_ok);
        end
        n_checks++;
        if (attempts != 3) begin
            n_fail++;
            $display("FAIL timeout_attempts: got %0d read attempts, expected 3", attempts);
        end
    endtask

    task automatic test_start_busy();
        stall_cfg = 0;
        do_reset();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_start_done: got done=%b pass=%b, expected 1 1", done, pass);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b1 || bus0.m_read !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start_dropped: got busy=%b done=%b read=%b, expected 0 1 0", busy, done, bus0.m_read);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (done !== 1'b0 || pass !== 1'b0 || busy !== 1'b1 || bus0.m_read !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_accept: got done=%b pass=%b busy=%b read=%b, expected 0 0 1 1",
                     done, pass, busy, bus0.m_read);
        end
        repeat (3) tick();
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_result: got done=%b pass=%b, expected 1 1", done, pass);
        end
    endtask

    task automatic test_reset_mid_read();
        stall_cfg = 3;
        do_reset();
        repeat (6) tick();
        n_checks++;
        if (bus0.m_read !== 1'b1 || bus0.m_address !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_setup: got read=%b addr=%b, expected 1 1", bus0.m_read, bus0.m_address);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus0.m_read !== 1'b0 || bus0.m_address !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async: got read=%b addr=%b busy=%b done=%b, expected 0 0 0 0",
                     bus0.m_read, bus0.m_address, busy, done);
        end
        tick();
        stall_cfg = 0;
        reset_n   = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b1 || captured_ts !== 32'h5AA979AC) begin
            n_fail++;
            $display("FAIL midrst_recheck: got done=%b pass=%b ts=%h, expected 1 1 5aa979ac", done, pass, captured_ts);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        start_t   = 1'b0;
        stall_cfg = 0;
        id_val    = 32'd0;
        ts_val    = 32'h5AA979AC;
        test_reset();
        test_auto_pass();
        test_ts_mismatch();
        test_waitrequest();
        test_timeout();
        test_start_busy();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
